// File: rtl/gpio_pad_pkg.sv
// Shared pad drive-mode encodings and the direction FSM state type.
package gpio_pad_pkg;

  localparam logic [2:0] DM_IN  = 3'b001;
  localparam logic [2:0] DM_HIZ = 3'b000;
  localparam logic [2:0] DM_OUT = 3'b110;

  typedef enum logic [1:0] {
    IN_MODE  = 2'd0,
    TURN     = 2'd1,
    OUT_MODE = 2'd2
  } pad_state_e;

  function automatic logic [2:0] dm_of(input pad_state_e s);
    case (s)
      OUT_MODE: dm_of = DM_OUT;
      TURN:     dm_of = DM_HIZ;
      default:  dm_of = DM_IN;
    endcase
  endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// Pad input 2-flop synchronizer plus optional debounce (GPIO_PAD_CTRL_DEB_EN).
// The level only advances while en is high; otherwise it holds.
module gpio_in_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  input  logic en,
  output logic in_val
);

  logic s1;
  logic sync;
  logic lvl_q;

  if (DEB_CYC < 1 || DEB_CYC > 255) begin : g_deb_range
    $error("DEB_CYC out of range 1..255");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      sync <= 1'b0;
    end else begin
      s1   <= pad_in;
      sync <= s1;
    end
  end

`ifdef GPIO_PAD_CTRL_DEB_EN
  logic [7:0] cnt_q;

  // Accept on the edge where the DEB_CYC-th mismatching cycle is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (!en || sync == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q == 8'(DEB_CYC - 1)) begin
      cnt_q <= '0;
      lvl_q <= sync;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign in_val = lvl_q;
`else
  // Pass-through keeps 2-cycle latency; lvl_q only remembers the held level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= in_val;
  end

  assign in_val = en ? sync : lvl_q;
`endif

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: direction FSM with turnaround, pad drive, edge irqs.
// Debounce is enabled by defining GPIO_PAD_CTRL_DEB_EN.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir_req,
  input  logic       out_val,
  input  logic       irq_clr,
  input  logic       pad_in,
  output logic       pad_out,
  output logic [2:0] pad_dm,
  output logic       in_val,
  output logic       rise_irq,
  output logic       fall_irq,
  output logic       busy
);

  pad_state_e state_q, state_d;
  logic       tgt_q, tgt_d;
  logic [3:0] turn_q, turn_d;
  logic       prev_q;

  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_turn_range
    $error("TURN_CYC out of range 1..15");
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    turn_d  = turn_q;
    unique case (state_q)
      IN_MODE: if (dir_req) begin
        state_d = TURN;
        tgt_d   = 1'b1;
        turn_d  = '0;
      end
      OUT_MODE: if (!dir_req) begin
        state_d = TURN;
        tgt_d   = 1'b0;
        turn_d  = '0;
      end
      TURN: begin
        // A reversed request mid-turn retargets and restarts the full turn.
        if (dir_req != tgt_q) begin
          tgt_d  = dir_req;
          turn_d = '0;
        end else if (turn_q == 4'(TURN_CYC - 1)) begin
          state_d = tgt_q ? OUT_MODE : IN_MODE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: state_d = IN_MODE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IN_MODE;
      tgt_q   <= 1'b0;
      turn_q  <= '0;
      pad_dm  <= DM_IN;
      busy    <= 1'b0;
      pad_out <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      turn_q  <= turn_d;
      pad_dm  <= dm_of(state_d);
      busy    <= (state_d == TURN);
      pad_out <= (state_q == OUT_MODE) & out_val;
    end
  end

  gpio_in_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_in (
    .clk    (clk),
    .rst    (rst),
    .pad_in (pad_in),
    .en     (state_q == IN_MODE),
    .in_val (in_val)
  );

  // Sticky edge flags; a new edge beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= 1'b0;
      rise_irq <= 1'b0;
      fall_irq <= 1'b0;
    end else begin
      prev_q   <= in_val;
      rise_irq <= (in_val & ~prev_q) | (rise_irq & ~irq_clr);
      fall_irq <= (~in_val & prev_q) | (fall_irq & ~irq_clr);
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed-vector bench for gpio_pad_ctrl (DEB_CYC=4, TURN_CYC=2).
module tb_gpio_pad_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir_req = 1'b0;
  logic       out_val = 1'b0;
  logic       irq_clr = 1'b0;
  logic       pad_in = 1'b0;
  logic       pad_out;
  logic [2:0] pad_dm;
  logic       in_val;
  logic       rise_irq;
  logic       fall_irq;
  logic       busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

`ifdef GPIO_PAD_CTRL_DEB_EN
  localparam int  LAT = 6;
  localparam bit  DEB = 1'b1;
`else
  localparam int  LAT = 2;
  localparam bit  DEB = 1'b0;
`endif

  gpio_pad_ctrl #(
    .DEB_CYC  (4),
    .TURN_CYC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dir_req  (dir_req),
    .out_val  (out_val),
    .irq_clr  (irq_clr),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_dm   (pad_dm),
    .in_val   (in_val),
    .rise_irq (rise_irq),
    .fall_irq (fall_irq),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_dm", pad_dm, 8'h01);
    check("rst_out", pad_out, 8'h0);
    check("rst_inval", in_val, 8'h0);
    check("rst_busy", busy, 8'h0);
    check("rst_irq", {rise_irq, fall_irq}, 8'h0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_dm", pad_dm, 8'h01);
    check("idle_busy", busy, 8'h0);
    check("idle_out", pad_out, 8'h0);

    // input -> output turnaround
    dir_req = 1'b1;
    out_val = 1'b1;
    tick();
    check("to_out_t1_dm", pad_dm, 8'h00);
    check("to_out_t1_busy", busy, 8'h1);
    tick();
    check("to_out_t2_dm", pad_dm, 8'h00);
    check("to_out_t2_busy", busy, 8'h1);
    tick();
    check("out_dm", pad_dm, 8'h06);
    check("out_busy", busy, 8'h0);
    check("out_first_pout", pad_out, 8'h0);
    tick();
    check("out_pout1", pad_out, 8'h1);
    out_val = 1'b0;
    tick();
    check("out_pout0", pad_out, 8'h0);
    out_val = 1'b1;
    tick();
    check("out_pout1b", pad_out, 8'h1);

    // output -> input turnaround
    out_val = 1'b0;
    dir_req = 1'b0;
    tick();
    check("to_in_t1_dm", pad_dm, 8'h00);
    tick();
    check("to_in_t2_dm", pad_dm, 8'h00);
    check("to_in_t2_pout", pad_out, 8'h0);
    tick();
    check("to_in_dm", pad_dm, 8'h01);
    check("to_in_busy", busy, 8'h0);

    // reversal in the first TURN cycle restarts the turn
    dir_req = 1'b1;
    tick();
    check("rev_t1_dm", pad_dm, 8'h00);
    dir_req = 1'b0;
    tick();
    check("rev_t2_dm", pad_dm, 8'h00);
    tick();
    check("rev_t3_dm", pad_dm, 8'h00);
    check("rev_t3_busy", busy, 8'h1);
    tick();
    check("rev_end_dm", pad_dm, 8'h01);
    check("rev_end_busy", busy, 8'h0);
    tick();
    check("rev_settled_dm", pad_dm, 8'h01);

    // 3-cycle glitch on pad_in
    pad_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) pad_in = 1'b0;
      check($sformatf("glitch_in_%0d", k), in_val, DEB ? 8'h0 : 8'((k >= 2) && (k <= 4)));
      check($sformatf("glitch_rise_%0d", k), rise_irq, DEB ? 8'h0 : 8'(k >= 3));
      check($sformatf("glitch_fall_%0d", k), fall_irq, DEB ? 8'h0 : 8'(k >= 6));
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("clr_after_glitch", {rise_irq, fall_irq}, 8'h0);

    // steady rise
    pad_in = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      check($sformatf("rise_in_%0d", k), in_val, 8'(k >= LAT));
      check($sformatf("rise_irq_%0d", k), rise_irq, 8'(k >= LAT + 1));
    end
    check("rise_no_fall", fall_irq, 8'h0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("rise_cleared", rise_irq, 8'h0);

    // fall coinciding with irq_clr: set wins
    pad_in = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("fall_in_%0d", k), in_val, 8'(k < LAT));
    end
    irq_clr = 1'b1;
    tick();
    check("fall_set_wins", fall_irq, 8'h1);
    check("fall_no_rise", rise_irq, 8'h0);
    tick();
    check("fall_cleared", fall_irq, 8'h0);
    irq_clr = 1'b0;

    // in_val holds outside IN_MODE
    pad_in = 1'b1;
    dir_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("hold_in_%0d", k), in_val, 8'h0);
    end
    check("hold_dm_out", pad_dm, 8'h06);
    dir_req = 1'b0;
    tick();
    tick();
    tick();
    check("hold_back_dm", pad_dm, 8'h01);
    check("hold_back_in", in_val, DEB ? 8'h0 : 8'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("hold_resume_%0d", k), in_val, DEB ? 8'(k >= 4) : 8'h1);
    end

    // reset asserted mid-TURN
    pad_in = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    dir_req = 1'b1;
    tick();
    check("midturn_busy", busy, 8'h1);
    #2 rst = 1'b1;
    #1;
    check("midturn_rst_dm", pad_dm, 8'h01);
    check("midturn_rst_busy", busy, 8'h0);
    check("midturn_rst_pout", pad_out, 8'h0);
    dir_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("after_rst_dm_%0d", k), pad_dm, 8'h01);
      check($sformatf("after_rst_busy_%0d", k), busy, 8'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 4, is the number of consecutive stable synchronized cycles required to accept a new input level (range 1..255).
REQ-002 Parameter TURN_CYC, default 2, is the number of cycles pad_dm is held at 3'b000 during a direction change (range 1..15).
REQ-003 One clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  input  1  block clock, all state rising-edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 dir_req  input  1  requested direction: 1 = output, 0 = input.
REQ-007 out_val  input  1  value to drive on the pad in output mode.
REQ-008 irq_clr  input  1  clears both sticky edge flags.
REQ-009 pad_in  input  1  pad receiver output, connected to the pad IN pin, asynchronous.
REQ-010 pad_out  output  1  connected to the pad OUT pin.
REQ-011 pad_dm  output  3  connected to the pad DM pins.
REQ-012 in_val  output  1  synchronized, debounced input level.
REQ-013 rise_irq / fall_irq  output  1 each  sticky rising- and falling-edge flags on in_val.
REQ-014 busy  output  1  high while in TURN.

Function
REQ-015 The FSM SHALL have states IN_MODE, TURN and OUT_MODE, with register tgt holding the target direction.
REQ-016 In IN_MODE with dir_req=1, the next state SHALL be TURN with tgt=1; in OUT_MODE with dir_req=0, the next state SHALL be TURN with tgt=0.
REQ-017 TURN SHALL last exactly TURN_CYC cycles, then go to OUT_MODE if tgt=1, else to IN_MODE.
REQ-018 If dir_req differs from tgt during TURN, tgt SHALL update and the turn counter SHALL restart at 0.
REQ-019 pad_dm SHALL be registered: 3'b001 in IN_MODE, 3'b000 in TURN, 3'b110 in OUT_MODE, updating in the same cycle as the state.
REQ-020 pad_out SHALL equal out_val registered 1 cycle in OUT_MODE, and 0 otherwise.
REQ-021 pad_in SHALL pass through a 2-flop synchronizer, producing sync.
REQ-022 In IN_MODE, the debounce counter SHALL increment while sync != in_val and clear when sync == in_val.
REQ-023 When the debounce counter reaches DEB_CYC, in_val SHALL take sync and the counter SHALL clear.
REQ-024 Outside IN_MODE, the debounce counter SHALL be held at 0 and in_val SHALL hold its value.
REQ-025 rise_irq SHALL set on an in_val 0->1 transition, and fall_irq SHALL set on a 1->0 transition.
REQ-026 irq_clr SHALL clear both edge flags; when a set and irq_clr occur in the same cycle, the set SHALL win.
REQ-027 busy SHALL be registered and asserted exactly when the state is TURN.

Reset
REQ-028 While rst is high: state=IN_MODE, tgt=0, pad_dm=3'b001, pad_out=0, sync flops=0, counters=0, in_val=0, rise_irq=0, fall_irq=0, busy=0.
REQ-029 Reset asserted mid-TURN SHALL abort the turn and return to IN_MODE with no OUT_MODE cycle.

Configuration
REQ-030 With GPIO_PAD_CTRL_DEB_EN defined, debounce SHALL operate per REQ-022..024.
REQ-031 Without GPIO_PAD_CTRL_DEB_EN, in_val SHALL equal sync gated by IN_MODE (hold rule unchanged), 2-cycle latency, and DEB_CYC SHALL be ignored.

Structure
REQ-032 Package gpio_pad_pkg SHALL hold the DM constants (DM_IN=3'b001, DM_HIZ=3'b000, DM_OUT=3'b110) and the FSM state typedef.
REQ-033 Synchronizer plus debounce SHALL be sub-module gpio_in_debounce, and the FSM, output and irq logic SHALL remain in gpio_pad_ctrl.

Verification
REQ-034 Reset then idle -> pad_dm=001, pad_out=0, in_val=0, busy=0.
REQ-035 dir_req 0->1, TURN_CYC=2 -> pad_dm 000 for exactly 2 cycles then 110, and pad_out follows out_val=1 one cycle later.
REQ-036 pad_in 0->1 held steady, DEB_CYC=4 -> in_val rises 6 cycles after the edge (2 sync + 4), and rise_irq sets.
REQ-037 pad_in glitch high for 3 cycles with DEB_CYC=4 -> in_val stays 0, and no irq.
REQ-038 dir_req toggled 1->0 at the first TURN cycle -> counter restarts, 2 further cycles at 000, then pad_dm=001, and OUT_MODE is never entered.
REQ-039 irq_clr asserted on the same cycle as a falling edge -> fall_irq=1 afterwards.
